id_stage_sb: RTL

Registered, parametrised RV32I decode stage with a valid/ready handshake on both sides and an internal ID/EX output register. It sits between the fetch queue and EX. It decodes each instruction, reads the register file and resolves operands through N prioritised forwarding ports. A per-register load scoreboard replaces the single-cycle load-use check. A flush input supports branch mispredict recovery, and a saturating stall counter supports performance analysis.

---
 rtl/id_pkg.sv | 81 ++++++++
 rtl/id_fwd_mux.sv | 26 ++
 rtl/id_stage_sb.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/id_pkg.sv
// rtl/id_pkg.sv - decode constants, decoded-field struct and immediate helpers for id_stage_sb
package id_pkg;

  localparam logic [2:0] ALUSEL_ARITH  = 3'd0;
  localparam logic [2:0] ALUSEL_LOGIC  = 3'd1;
  localparam logic [2:0] ALUSEL_SHIFT  = 3'd2;
  localparam logic [2:0] ALUSEL_LOAD   = 3'd3;
  localparam logic [2:0] ALUSEL_SAVE   = 3'd4;
  localparam logic [2:0] ALUSEL_BRANCH = 3'd5;
  localparam logic [2:0] ALUSEL_NOP    = 3'd7;

  localparam logic [3:0] EX_ADD = 4'd0, EX_SUB = 4'd1, EX_SLT = 4'd2, EX_SLTU = 4'd3;
  localparam logic [3:0] EX_LUI = 4'd4, EX_AUIPC = 4'd5;
  localparam logic [3:0] EX_AND = 4'd0, EX_OR = 4'd1, EX_XOR = 4'd2;
  localparam logic [3:0] EX_SLL = 4'd0, EX_SRL = 4'd1, EX_SRA = 4'd2;
  // Load, store and branch aluops are the instruction funct3 zero-extended.
  localparam logic [3:0] EX_LB = 4'd0, EX_LH = 4'd1, EX_LW = 4'd2, EX_LBU = 4'd4, EX_LHU = 4'd5;
  localparam logic [3:0] EX_SB = 4'd0, EX_SH = 4'd1, EX_SW = 4'd2;
  localparam logic [3:0] EX_BEQ = 4'd0, EX_BNE = 4'd1, EX_BLT = 4'd4, EX_BGE = 4'd5;
  localparam logic [3:0] EX_BLTU = 4'd6, EX_BGEU = 4'd7, EX_JAL = 4'd8, EX_JALR = 4'd9;

  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OPIMM  = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;

  typedef enum logic [1:0] {OP1_ZERO, OP1_RS1, OP1_IMM} op1_sel_e;
  typedef enum logic [1:0] {OP2_ZERO, OP2_RS2, OP2_IMM, OP2_PC} op2_sel_e;

  typedef struct packed {
    logic [2:0]  alusel;
    logic [3:0]  aluop;
    logic [31:0] imm;
    logic        wen;
    logic        illegal;
    logic        rs1_used;
    logic        rs2_used;
    op1_sel_e    op1_sel;
    op2_sel_e    op2_sel;
  } dec_t;

  function automatic logic [31:0] imm_i(input logic [31:0] i);
    return {{20{i[31]}}, i[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] i);
    return {{20{i[31]}}, i[31:25], i[11:7]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] i);
    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] i);
    return {i[31:12], 12'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] i);
    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
  endfunction

  // Shared OP / OP-IMM class mapping; alt selects SUB/SRA.
  function automatic logic [6:0] alu_map(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    return {ALUSEL_ARITH, alt ? EX_SUB : EX_ADD};
      3'd1:    return {ALUSEL_SHIFT, EX_SLL};
      3'd2:    return {ALUSEL_ARITH, EX_SLT};
      3'd3:    return {ALUSEL_ARITH, EX_SLTU};
      3'd4:    return {ALUSEL_LOGIC, EX_XOR};
      3'd5:    return {ALUSEL_SHIFT, alt ? EX_SRA : EX_SRL};
      3'd6:    return {ALUSEL_LOGIC, EX_OR};
      default: return {ALUSEL_LOGIC, EX_AND};
    endcase
  endfunction

endpackage

// File: rtl/id_fwd_mux.sv
// rtl/id_fwd_mux.sv - resolves one source operand from x0, prioritised forward ports or the register file
module id_fwd_mux #(
  parameter int XLEN    = 32,
  parameter int REG_AW  = 5,
  parameter int NUM_FWD = 2
) (
  input  logic [REG_AW-1:0]         addr_i,
  input  logic [XLEN-1:0]           rf_data_i,
  input  logic [NUM_FWD-1:0]        fwd_valid_i,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_addr_i,
  input  logic [NUM_FWD*XLEN-1:0]   fwd_data_i,
  output logic [XLEN-1:0]           data_o
);

  // Scan oldest to youngest so port 0 overrides everything else.
  always_comb begin
    data_o = rf_data_i;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (fwd_valid_i[i] && (fwd_addr_i[i*REG_AW +: REG_AW] == addr_i))
        data_o = fwd_data_i[i*XLEN +: XLEN];
    end
    if (addr_i == '0)
      data_o = '0;
  end

endmodule

// File: rtl/id_stage_sb.sv
// rtl/id_stage_sb.sv - RV32I decode stage with forwarding, load scoreboard and ID/EX output register
module id_stage_sb
  import id_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int REG_AW   = 5,
  parameter int NUM_FWD  = 2,
  parameter int LOAD_LAT = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [XLEN-1:0]           in_pc,
  input  logic [31:0]               in_instr,
  input  logic                      in_pred,
  output logic [REG_AW-1:0]         rs1_addr,
  output logic [REG_AW-1:0]         rs2_addr,
  input  logic [XLEN-1:0]           rs1_data,
  input  logic [XLEN-1:0]           rs2_data,
  input  logic [NUM_FWD-1:0]        fwd_valid,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_addr,
  input  logic [NUM_FWD*XLEN-1:0]   fwd_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [XLEN-1:0]           out_pc,
  output logic                      out_pred,
  output logic [2:0]                out_alusel,
  output logic [3:0]                out_aluop,
  output logic [XLEN-1:0]           out_op1,
  output logic [XLEN-1:0]           out_op2,
  output logic [XLEN-1:0]           out_imm,
  output logic                      out_wen,
  output logic [REG_AW-1:0]         out_rd,
  output logic                      out_illegal,
  output logic [31:0]               stall_cycles
);

  localparam int         NREG = 2**REG_AW;
  localparam logic [2:0] LAT  = 3'(LOAD_LAT);

  logic [6:0]        opcode, f7;
  logic [2:0]        f3;
  logic [REG_AW-1:0] rd;
  dec_t              dec;
  logic              bad;

  assign opcode = in_instr[6:0];
  assign f3     = in_instr[14:12];
  assign f7     = in_instr[31:25];
  assign rd     = REG_AW'(in_instr[11:7]);

  always_comb begin
    dec = '0;
    bad = 1'b0;
    case (opcode)
      OPC_LUI: begin
        {dec.alusel, dec.aluop} = {ALUSEL_ARITH, EX_LUI};
        dec.imm = imm_u(in_instr); dec.op1_sel = OP1_IMM; dec.wen = 1'b1;
      end
      OPC_AUIPC: begin
        {dec.alusel, dec.aluop} = {ALUSEL_ARITH, EX_AUIPC};
        dec.imm = imm_u(in_instr); dec.op1_sel = OP1_IMM; dec.op2_sel = OP2_PC; dec.wen = 1'b1;
      end
      OPC_JAL: begin
        {dec.alusel, dec.aluop} = {ALUSEL_BRANCH, EX_JAL};
        dec.imm = imm_j(in_instr); dec.wen = 1'b1;
      end
      OPC_JALR: begin
        {dec.alusel, dec.aluop} = {ALUSEL_BRANCH, EX_JALR};
        dec.imm = imm_i(in_instr); dec.wen = 1'b1;
        dec.rs1_used = 1'b1; dec.op1_sel = OP1_RS1;
        bad = (f3 != 3'd0);
      end
      OPC_BRANCH: begin
        {dec.alusel, dec.aluop} = {ALUSEL_BRANCH, 1'b0, f3};
        dec.imm = imm_b(in_instr);
        dec.rs1_used = 1'b1; dec.rs2_used = 1'b1; dec.op1_sel = OP1_RS1; dec.op2_sel = OP2_RS2;
        bad = (f3 == 3'd2) || (f3 == 3'd3);
      end
      OPC_LOAD: begin
        {dec.alusel, dec.aluop} = {ALUSEL_LOAD, 1'b0, f3};
        dec.imm = imm_i(in_instr); dec.wen = 1'b1;
        dec.rs1_used = 1'b1; dec.op1_sel = OP1_RS1;
        bad = (f3 == 3'd3) || (f3 >= 3'd6);
      end
      OPC_STORE: begin
        {dec.alusel, dec.aluop} = {ALUSEL_SAVE, 1'b0, f3};
        dec.imm = imm_s(in_instr);
        dec.rs1_used = 1'b1; dec.rs2_used = 1'b1; dec.op1_sel = OP1_RS1; dec.op2_sel = OP2_RS2;
        bad = (f3 >= 3'd3);
      end
      OPC_OPIMM: begin
        {dec.alusel, dec.aluop} = alu_map(f3, (f3 == 3'd5) && f7[5]);
        dec.imm = imm_i(in_instr); dec.wen = 1'b1;
        dec.rs1_used = 1'b1; dec.op1_sel = OP1_RS1; dec.op2_sel = OP2_IMM;
        bad = ((f3 == 3'd1) && (f7 != 7'h00)) ||
              ((f3 == 3'd5) && (f7 != 7'h00) && (f7 != 7'h20));
      end
      OPC_OP: begin
        {dec.alusel, dec.aluop} = alu_map(f3, f7[5]);
        dec.wen = 1'b1;
        dec.rs1_used = 1'b1; dec.rs2_used = 1'b1; dec.op1_sel = OP1_RS1; dec.op2_sel = OP2_RS2;
        bad = !((f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5))));
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      dec         = '0;
      dec.alusel  = ALUSEL_NOP;
      dec.illegal = 1'b1;
    end
  end

  assign rs1_addr = dec.rs1_used ? REG_AW'(in_instr[19:15]) : '0;
  assign rs2_addr = dec.rs2_used ? REG_AW'(in_instr[24:20]) : '0;

  logic [XLEN-1:0] rs1_val, rs2_val, imm_x, op1, op2;

  id_fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW), .NUM_FWD(NUM_FWD)) u_fwd_rs1 (
    .addr_i(rs1_addr), .rf_data_i(rs1_data), .fwd_valid_i(fwd_valid),
    .fwd_addr_i(fwd_addr), .fwd_data_i(fwd_data), .data_o(rs1_val)
  );

  id_fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW), .NUM_FWD(NUM_FWD)) u_fwd_rs2 (
    .addr_i(rs2_addr), .rf_data_i(rs2_data), .fwd_valid_i(fwd_valid),
    .fwd_addr_i(fwd_addr), .fwd_data_i(fwd_data), .data_o(rs2_val)
  );

  assign imm_x = XLEN'($signed(dec.imm));

  always_comb begin
    case (dec.op1_sel)
      OP1_RS1: op1 = rs1_val;
      OP1_IMM: op1 = imm_x;
      default: op1 = '0;
    endcase
    case (dec.op2_sel)
      OP2_RS2: op2 = rs2_val;
      OP2_IMM: op2 = imm_x;
      OP2_PC:  op2 = in_pc;
      default: op2 = '0;
    endcase
  end

  logic [2:0]  cnt_q [NREG];
  logic [2:0]  cnt_d [NREG];
  logic [31:0] stall_q, stall_d;
  logic        out_valid_q;
  logic        hazard, adv, fire, ld_set;

  // The scoreboard blocks on a pending load even when a forward port could supply it.
  assign hazard   = in_valid && ((dec.rs1_used && (cnt_q[rs1_addr] != 3'd0)) ||
                                 (dec.rs2_used && (cnt_q[rs2_addr] != 3'd0)));
  assign adv      = !out_valid_q || out_ready;
  assign in_ready = rst && adv && !hazard && !flush;
  assign fire     = in_valid && in_ready;
  assign ld_set   = fire && (dec.alusel == ALUSEL_LOAD) && (rd != '0);

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
      if (adv) begin
        if (ld_set && (rd == REG_AW'(r)))
          cnt_d[r] = LAT;
        else if (cnt_q[r] != 3'd0)
          cnt_d[r] = cnt_q[r] - 3'd1;
      end
    end
    stall_d = stall_q;
    if (in_valid && adv && hazard && (stall_q != 32'hFFFF_FFFF))
      stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= 3'd0;
      stall_q <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= flush ? 3'd0 : cnt_d[r];
      stall_q <= stall_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_pc      <= '0;
      out_pred    <= 1'b0;
      out_alusel  <= '0;
      out_aluop   <= '0;
      out_op1     <= '0;
      out_op2     <= '0;
      out_imm     <= '0;
      out_wen     <= 1'b0;
      out_rd      <= '0;
      out_illegal <= 1'b0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (adv) begin
      out_valid_q <= fire;
      if (fire) begin
        out_pc      <= in_pc;
        out_pred    <= in_pred;
        out_alusel  <= dec.alusel;
        out_aluop   <= dec.aluop;
        out_op1     <= op1;
        out_op2     <= op2;
        out_imm     <= imm_x;
        out_wen     <= dec.wen && (rd != '0);
        out_rd      <= dec.wen ? rd : '0;
        out_illegal <= dec.illegal;
      end
    end
  end

  assign out_valid    = out_valid_q;
  assign stall_cycles = stall_q;

endmodule
